// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store request stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/lsu_align_decode.sv
// Combinational access decode: byte enables, lane-replicated store data and
// alignment/legality checks derived from the low address bits and funct3.
module lsu_align_decode
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  f3,
    input  logic        is_store,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misaligned,
    output logic        illegal
);

    always_comb begin
        be         = BE_NONE;
        lane_wdata = wdata;
        misaligned = 1'b0;
        illegal    = 1'b0;

        case (f3)
            F3_LB, F3_LBU: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            F3_LH, F3_LHU: begin
                be         = 4'b0011 << addr_lo;
                lane_wdata = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            F3_LW: begin
                be         = 4'b1111;
                lane_wdata = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase

        // Stores have no unsigned variants; an illegal op never reports misalignment.
        if (is_store && f3[2]) begin
            illegal = 1'b1;
        end
        if (illegal) begin
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/lsu_mem_request.sv
// Load/store request stage: accepts one op, issues the aligned bus request,
// waits for the response with a timeout and hands the raw word downstream.
module lsu_mem_request
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_f3,
    input  logic        in_is_store,
    input  logic [4:0]  in_rd,

    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_rdata,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] memory_data,
    output logic [3:0]  byte_enable_mask,
    output logic [2:0]  f3,
    output logic [4:0]  out_rd,
    output logic        out_is_store,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_error
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic        bus_req_valid_q, bus_req_valid_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] memory_data_q, memory_data_d;
    logic [3:0]  mask_q, mask_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_store_q, is_store_d;
    logic        misaligned_q, misaligned_d;
    logic        illegal_q, illegal_d;
    logic        bus_error_q, bus_error_d;

    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;
    logic        dec_misaligned;
    logic        dec_illegal;

    lsu_align_decode u_decode (
        .addr_lo    (in_addr[1:0]),
        .f3         (in_f3),
        .is_store   (in_is_store),
        .wdata      (in_wdata),
        .be         (dec_be),
        .lane_wdata (dec_wdata),
        .misaligned (dec_misaligned),
        .illegal    (dec_illegal)
    );

    always_comb begin
        state_d         = state_q;
        bus_req_valid_d = bus_req_valid_q;
        bus_addr_d      = bus_addr_q;
        bus_we_d        = bus_we_q;
        bus_be_d        = bus_be_q;
        bus_wdata_d     = bus_wdata_q;
        cnt_d           = cnt_q;
        out_valid_d     = out_valid_q;
        memory_data_d   = memory_data_q;
        mask_d          = mask_q;
        f3_d            = f3_q;
        rd_d            = rd_q;
        is_store_d      = is_store_q;
        misaligned_d    = misaligned_q;
        illegal_d       = illegal_q;
        bus_error_d     = bus_error_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    f3_d          = in_f3;
                    rd_d          = in_rd;
                    is_store_d    = in_is_store;
                    memory_data_d = 32'd0;
                    bus_addr_d    = {in_addr[31:2], 2'b00};
                    bus_we_d      = in_is_store;
                    bus_be_d      = dec_be;
                    bus_wdata_d   = dec_wdata;
                    cnt_d         = '0;
                    // Faulting ops skip the bus entirely and report straight away.
                    if (dec_illegal || dec_misaligned) begin
                        mask_d       = BE_NONE;
                        illegal_d    = dec_illegal;
                        misaligned_d = dec_misaligned;
                        out_valid_d  = 1'b1;
                        state_d      = DONE;
                    end else begin
                        mask_d          = dec_be;
                        bus_req_valid_d = 1'b1;
                        state_d         = REQ;
                    end
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    bus_req_valid_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (bus_resp_valid) begin
                    memory_data_d = is_store_q ? 32'd0 : bus_rdata;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_error_d   = 1'b1;
                    mask_d        = BE_NONE;
                    memory_data_d = 32'd0;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d  = 1'b0;
                    misaligned_d = 1'b0;
                    illegal_d    = 1'b0;
                    bus_error_d  = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            bus_req_valid_q <= 1'b0;
            bus_addr_q      <= 32'd0;
            bus_we_q        <= 1'b0;
            bus_be_q        <= BE_NONE;
            bus_wdata_q     <= 32'd0;
            cnt_q           <= '0;
            out_valid_q     <= 1'b0;
            memory_data_q   <= 32'd0;
            mask_q          <= BE_NONE;
            f3_q            <= 3'd0;
            rd_q            <= 5'd0;
            is_store_q      <= 1'b0;
            misaligned_q    <= 1'b0;
            illegal_q       <= 1'b0;
            bus_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_addr_q      <= bus_addr_d;
            bus_we_q        <= bus_we_d;
            bus_be_q        <= bus_be_d;
            bus_wdata_q     <= bus_wdata_d;
            cnt_q           <= cnt_d;
            out_valid_q     <= out_valid_d;
            memory_data_q   <= memory_data_d;
            mask_q          <= mask_d;
            f3_q            <= f3_d;
            rd_q            <= rd_d;
            is_store_q      <= is_store_d;
            misaligned_q    <= misaligned_d;
            illegal_q       <= illegal_d;
            bus_error_q     <= bus_error_d;
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign bus_req_valid    = bus_req_valid_q;
    assign bus_addr         = bus_addr_q;
    assign bus_we           = bus_we_q;
    assign bus_be           = bus_be_q;
    assign bus_wdata        = bus_wdata_q;
    assign out_valid        = out_valid_q;
    assign memory_data      = memory_data_q;
    assign byte_enable_mask = mask_q;
    assign f3               = f3_q;
    assign out_rd           = rd_q;
    assign out_is_store     = is_store_q;
    assign misaligned       = misaligned_q;
    assign illegal          = illegal_q;
    assign bus_error        = bus_error_q;

endmodule

// File: tb/tb_lsu_mem_request.sv
// Directed bench for lsu_mem_request: expected results are queued when an op
// is driven and compared field by field when the stage presents its result.
module tb_lsu_mem_request;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  mask;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        st;
        logic        mis;
        logic        ill;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_f3;
    logic        in_is_store;
    logic [4:0]  in_rd;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] memory_data;
    logic [3:0]  byte_enable_mask;
    logic [2:0]  f3;
    logic [4:0]  out_rd;
    logic        out_is_store;
    logic        misaligned;
    logic        illegal;
    logic        bus_error;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    lsu_mem_request #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_addr          (in_addr),
        .in_wdata         (in_wdata),
        .in_f3            (in_f3),
        .in_is_store      (in_is_store),
        .in_rd            (in_rd),
        .bus_req_valid    (bus_req_valid),
        .bus_req_ready    (bus_req_ready),
        .bus_addr         (bus_addr),
        .bus_we           (bus_we),
        .bus_be           (bus_be),
        .bus_wdata        (bus_wdata),
        .bus_resp_valid   (bus_resp_valid),
        .bus_rdata        (bus_rdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .memory_data      (memory_data),
        .byte_enable_mask (byte_enable_mask),
        .f3               (f3),
        .out_rd           (out_rd),
        .out_is_store     (out_is_store),
        .misaligned       (misaligned),
        .illegal          (illegal),
        .bus_error        (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] data, input logic [3:0] mask,
                                   input logic [2:0] f3v, input logic [4:0] rd,
                                   input logic st, input logic mis, input logic ill,
                                   input logic err);
        exp_t e;
        e.data = data; e.mask = mask; e.f3 = f3v; e.rd = rd;
        e.st = st; e.mis = mis; e.ill = ill; e.err = err;
        return e;
    endfunction

    // Waits for the stage to be idle, drives one op for one accept edge and
    // optionally queues the result it must eventually produce.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3v, input logic st, input logic [4:0] rd,
                                 input exp_t e, input bit push);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkEq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_addr     = addr;
        in_wdata    = wdata;
        in_f3       = f3v;
        in_is_store = st;
        in_rd       = rd;
        in_valid    = 1'b1;
        if (push) sb_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    // Pops the oldest expectation and compares it against the presented result.
    task automatic checkOutput();
        exp_t e;
        checkEq("out_valid", {31'd0, out_valid}, 32'd1);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty: got result with no expectation queued");
        end else begin
            e = sb_q.pop_front();
            checkEq("memory_data", memory_data, e.data);
            checkEq("mask", {28'd0, byte_enable_mask}, {28'd0, e.mask});
            checkEq("f3", {29'd0, f3}, {29'd0, e.f3});
            checkEq("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
            checkEq("flags", {28'd0, out_is_store, misaligned, illegal, bus_error},
                    {28'd0, e.st, e.mis, e.ill, e.err});
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkEq("out_valid_after_consume", {31'd0, out_valid}, 32'd0);
        checkEq("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_addr        = 32'd0;
        in_wdata       = 32'd0;
        in_f3          = 3'd0;
        in_is_store    = 1'b0;
        in_rd          = 5'd0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_rdata      = 32'd0;
        out_ready      = 1'b0;

        // Reset state
        tick();
        tick();
        checkEq("rst_bus_req_valid", {31'd0, bus_req_valid}, 32'd0);
        checkEq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkEq("rst_memory_data", memory_data, 32'd0);
        checkEq("rst_mask_flags", {24'd0, byte_enable_mask, misaligned, illegal, bus_error, out_is_store},
                32'd0);
        checkEq("rst_bus_fields", bus_addr | bus_wdata | {27'd0, bus_we, bus_be}, 32'd0);
        rst_n = 1'b1;
        tick();

        // LW 0x1000, zero-wait memory
        $display("[TB] LW zero-wait");
        bus_req_ready = 1'b1;
        applyStimulus(32'h0000_1000, 32'd0, 3'b010, 1'b0, 5'd7,
                      mkExp(32'hDEAD_BEEF, 4'b1111, 3'b010, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        checkEq("lw_req_valid", {31'd0, bus_req_valid}, 32'd1);
        checkEq("lw_bus_addr", bus_addr, 32'h0000_1000);
        checkEq("lw_be_we", {27'd0, bus_we, bus_be}, {27'd0, 1'b0, 4'b1111});
        checkEq("lw_in_ready_busy", {31'd0, in_ready}, 32'd0);
        tick();
        checkEq("lw_req_dropped", {31'd0, bus_req_valid}, 32'd0);
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'hDEAD_BEEF;
        checkEq("lw_not_yet_valid", {31'd0, out_valid}, 32'd0);
        tick();
        bus_resp_valid = 1'b0;
        bus_rdata      = 32'd0;
        checkOutput();
        consume();

        // SB 0x2003 with byte replicated to every lane
        $display("[TB] SB lane replication");
        applyStimulus(32'h0000_2003, 32'h0000_00A5, 3'b000, 1'b1, 5'd0,
                      mkExp(32'd0, 4'b1000, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        checkEq("sb_bus_addr", bus_addr, 32'h0000_2000);
        checkEq("sb_be_we", {27'd0, bus_we, bus_be}, {27'd0, 1'b1, 4'b1000});
        checkEq("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
        tick();
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'h1234_5678;
        tick();
        bus_resp_valid = 1'b0;
        checkOutput();
        consume();

        // Misaligned LH and illegal f3 never touch the bus
        $display("[TB] faults");
        applyStimulus(32'h0000_0001, 32'd0, 3'b001, 1'b0, 5'd3,
                      mkExp(32'd0, 4'b0000, 3'b001, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
        checkEq("mis_no_req", {31'd0, bus_req_valid}, 32'd0);
        checkOutput();
        consume();
        applyStimulus(32'h0000_0000, 32'd0, 3'b011, 1'b0, 5'd4,
                      mkExp(32'd0, 4'b0000, 3'b011, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1);
        checkEq("ill_no_req", {31'd0, bus_req_valid}, 32'd0);
        checkOutput();
        consume();
        // Unsigned-store encoding is illegal even when misaligned
        applyStimulus(32'h0000_0001, 32'd0, 3'b101, 1'b1, 5'd5,
                      mkExp(32'd0, 4'b0000, 3'b101, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0), 1'b1);
        checkEq("ill_st_no_req", {31'd0, bus_req_valid}, 32'd0);
        checkOutput();
        consume();

        // Backpressure on both the request and the result
        $display("[TB] backpressure");
        bus_req_ready = 1'b0;
        applyStimulus(32'h0000_0042, 32'h1234_ABCD, 3'b001, 1'b1, 5'd9,
                      mkExp(32'd0, 4'b1100, 3'b001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkEq("bp_req_valid", {31'd0, bus_req_valid}, 32'd1);
            checkEq("bp_addr", bus_addr, 32'h0000_0040);
            checkEq("bp_wdata", bus_wdata, 32'hABCD_ABCD);
            checkEq("bp_be_we", {27'd0, bus_we, bus_be}, {27'd0, 1'b1, 4'b1100});
            tick();
        end
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'h9999_9999;
        tick();
        bus_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkEq("hold_out_valid", {31'd0, out_valid}, 32'd1);
            checkEq("hold_in_ready", {31'd0, in_ready}, 32'd0);
            checkEq("hold_mask_data", memory_data | {28'd0, byte_enable_mask}, 32'h0000_000C);
            tick();
        end
        checkOutput();
        consume();

        // Response timeout with TIMEOUT_CYCLES = 4
        $display("[TB] timeout");
        bus_req_ready = 1'b1;
        applyStimulus(32'h0000_4000, 32'd0, 3'b010, 1'b0, 5'd12,
                      mkExp(32'd0, 4'b0000, 3'b010, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
        tick();
        bus_req_ready = 1'b0;
        checkEq("to_req_dropped", {31'd0, bus_req_valid}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkEq("to_waiting", {30'd0, out_valid, bus_error}, 32'd0);
        end
        tick();
        checkEq("to_fired", {30'd0, out_valid, bus_error}, 32'd3);
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'hFFFF_FFFF;
        tick();
        bus_resp_valid = 1'b0;
        checkOutput();
        consume();
        bus_resp_valid = 1'b1;
        tick();
        bus_resp_valid = 1'b0;
        checkEq("late_resp_idle", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset during REQ drops the request without waiting for a clock edge
        $display("[TB] reset mid-operation");
        applyStimulus(32'h0000_6000, 32'd0, 3'b010, 1'b0, 5'd1, mkExp('0, '0, '0, '0, 0, 0, 0, 0), 1'b0);
        checkEq("rst_req_before", {31'd0, bus_req_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        checkEq("rst_req_async", {31'd0, bus_req_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during WAIT_RESP, then a stale response after release
        bus_req_ready = 1'b1;
        applyStimulus(32'h0000_5000, 32'd0, 3'b010, 1'b0, 5'd2, mkExp('0, '0, '0, '0, 0, 0, 0, 0), 1'b0);
        tick();
        bus_req_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        checkEq("rst_wait_outputs", {28'd0, bus_req_valid, out_valid, bus_error, misaligned | illegal},
                32'd0);
        checkEq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'hBAD0_BAD0;
        tick();
        bus_resp_valid = 1'b0;
        checkEq("rst_stale_resp", {30'd0, out_valid, in_ready}, 32'd1);

        // LBU 0x3002 after recovery
        bus_req_ready = 1'b1;
        applyStimulus(32'h0000_3002, 32'd0, 3'b100, 1'b0, 5'd31,
                      mkExp(32'h1122_3344, 4'b0100, 3'b100, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
        checkEq("lbu_be", {28'd0, bus_be}, 32'h4);
        checkEq("lbu_addr", bus_addr, 32'h0000_3000);
        tick();
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'h1122_3344;
        tick();
        bus_resp_valid = 1'b0;
        checkOutput();
        consume();

        checkEq("scoreboard_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_request.md
Name: lsu_mem_request

Overview:
Load/store request stage between execute and the load data formatter.
- Takes one memory op per handshake from execute.
- Builds the word-aligned bus request, byte-enable mask and lane-replicated store data.
- Detects misaligned or illegal accesses before anything reaches the bus.
- Waits for the bus response, with a timeout.
- Hands raw word data, mask and f3 downstream to the formatter/writeback stage.
- One operation outstanding at a time.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT_RESP before the op aborts with bus_error; must be >= 1
CNT_W, 8, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  the single clock
rst_n  in  1  reset, asynchronous and active-low
in_valid  in  1  execute presents an op
in_ready  out  1  stage can accept an op
in_addr  in  32  effective byte address
in_wdata  in  32  store data, right-aligned
in_f3  in  3  funct3 of the load/store
in_is_store  in  1  1 = store, 0 = load
in_rd  in  5  destination register
bus_req_valid  out  1  request to data memory
bus_req_ready  in  1  memory accepts request
bus_addr  out  32  word address: in_addr with [1:0] forced to 00
bus_we  out  1  write enable
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_resp_valid  in  1  response or write ack, one cycle
bus_rdata  in  32  read word
out_valid  out  1  result available downstream
out_ready  in  1  downstream consumes result
memory_data  out  32  captured read word (0 for stores and faults)
byte_enable_mask  out  4  mask used (0 on fault)
f3  out  3  f3 of completed op
out_rd  out  5  rd of completed op
out_is_store  out  1  completed op was a store
misaligned  out  1  alignment fault
illegal  out  1  unsupported f3
bus_error  out  1  response timeout

Behaviour:
- States: IDLE, REQ, WAIT_RESP, DONE. Reset forces IDLE.
- On reset, every output register is 0: bus_req_valid, out_valid, all data, mask and flag outputs, and the counter.
- in_ready = (state == IDLE). All handshakes complete on valid & ready at the clk rising edge.
- Decode in IDLE, combinational from the inputs; results are registered on accept.
  - f3 000/100 (byte): be = 0001 << addr[1:0]; wdata = {4{in_wdata[7:0]}}.
  - f3 001/101 (half): be = 0011 << addr[1:0]; wdata = {2{in_wdata[15:0]}}; misaligned if addr[0] = 1.
  - f3 010 (word): be = 1111; wdata = in_wdata; misaligned if addr[1:0] != 00.
  - illegal if f3 is 011, 110 or 111, or if a store has f3[2] = 1.
  - illegal has priority over misaligned.
- IDLE, accept:
  - Fault: go to DONE with mask = 0, memory_data = 0 and the matching flag. No bus activity.
  - Otherwise: go to REQ, bus_req_valid = 1.
- REQ:
  - Hold bus_addr, bus_we, bus_be and bus_wdata stable while bus_req_valid = 1 and bus_req_ready = 0.
  - On bus_req_ready: drop req_valid, clear the counter, go to WAIT_RESP.
- WAIT_RESP:
  - On bus_resp_valid: capture bus_rdata for loads (store: memory_data = 0), go to DONE, out_valid = 1.
  - Otherwise the counter increments. When counter == TIMEOUT_CYCLES - 1 and no response arrives, go to DONE with bus_error = 1, mask = 0.
  - The cycle count from REQ→WAIT_RESP to entering DONE is therefore TIMEOUT_CYCLES.
  - A bus_resp_valid that arrives in any state other than WAIT_RESP is ignored.
- bus_resp_valid in the same cycle as REQ→WAIT_RESP is not possible: the bus contract requires response ≥ 1 cycle after acceptance.
- DONE:
  - out_valid = 1; all out_* and flag outputs are held stable until out_ready.
  - On out_ready: out_valid = 0, go to IDLE, flags cleared.
  - No accept in the same cycle; the next accept is possible the cycle after.
- Latency for a load with zero-wait memory: accept at cycle 0 → REQ; bus accepts at cycle 1; response at cycle 2 → out_valid from cycle 3.
- Reset asserted mid-operation aborts immediately: bus_req_valid drops asynchronously and no result is produced. A late response after reset release is ignored, because the FSM is in IDLE.

Decomposition:
- Shared package lsu_pkg holds:
  - typedef lsu_state_t {IDLE, REQ, WAIT_RESP, DONE}.
  - localparams F3_LB/LH/LW/LBU/LHU (000/001/010/100/101) and F3_SB/SH/SW.
  - BE_NONE = 4'b0000.
- One combinational sub-module, lsu_align_decode (addr[1:0], f3, is_store, wdata → be, lane data, misaligned, illegal), instantiated once.
- The FSM, timeout counter and output registers stay in the top level.

Test Plan:
- LW at addr 0x1000, memory returns 0xDEADBEEF with no waits → bus_addr 0x1000, be 1111, memory_data 0xDEADBEEF, out_valid three cycles after accept.
- SB addr 0x2003, wdata 0x000000A5 → bus_be 1000, bus_wdata 0xA5A5A5A5, bus_we 1, out_is_store 1, memory_data 0.
- LH at addr 0x0001 → no bus_req_valid ever; misaligned = 1, mask 0000, out_valid in the cycle after accept. Repeat with f3 = 011 → illegal = 1.
- Backpressure: bus_req_ready low for 5 cycles, then out_ready low for 4 cycles → request fields stable throughout; outputs stable until out_ready; in_ready low until one cycle after out_ready.
- TIMEOUT_CYCLES = 4, memory never responds → bus_error = 1 exactly 4 cycles after bus acceptance; a late bus_resp_valid afterwards does not change outputs.
- rst_n low while in WAIT_RESP → bus_req_valid, out_valid and flags go 0 asynchronously; after release in_ready = 1 and a new LBU at addr 0x3002 returns be 0100.
